// File: rtl/conv10x10_seq_pkg.sv
// Shared types and geometry for the 10x10 convolution sequencer.
package conv10x10_pkg;

    localparam int unsigned ROWS   = 10;
    localparam int unsigned ROW_W  = 20;
    localparam int unsigned FILT_W = 18;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned N_OUT  = 8;
    localparam int unsigned PE_W   = ROWS * ROW_W;
    localparam int unsigned RES_W  = N_OUT * OUT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int unsigned row_lsb(input logic [3:0] i);
        return int'(i) * ROW_W;
    endfunction

endpackage

// File: rtl/conv10x10_seq_if.sv
// Bundle of the source, array and result-stream signals around the sequencer.
interface conv10x10_seq_if;
    import conv10x10_pkg::*;

    logic [FILT_W-1:0] filt_data;
    logic              filt_load;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic              abort;
    logic [PE_W-1:0]   pe_in;
    logic [FILT_W-1:0] pe_filter;
    logic [RES_W-1:0]  pe_out;
    logic [OUT_W-1:0]  res_data;
    logic [2:0]        res_idx;
    logic              res_valid;
    logic              res_ready;
    logic              res_last;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  filt_data, filt_load, row_data, row_valid, abort, pe_out, res_ready,
        output row_ready, pe_in, pe_filter, res_data, res_idx, res_valid, res_last,
               busy, frame_done
    );

    modport master (
        output filt_data, filt_load, row_data, row_valid, abort, pe_out, res_ready,
        input  row_ready, pe_in, pe_filter, res_data, res_idx, res_valid, res_last,
               busy, frame_done
    );

endinterface

// File: rtl/conv10x10_seq_res_drain.sv
// Captures the array result and serialises it as eight words over valid/ready.
module conv10x10_res_drain
    import conv10x10_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_abort,
    input  logic             i_capture,
    input  logic [RES_W-1:0] i_pe_out,
    input  logic             i_res_ready,
    output logic [OUT_W-1:0] o_res_data,
    output logic [2:0]       o_res_idx,
    output logic             o_res_valid,
    output logic             o_res_last,
    output logic             o_last_hs
);

    logic [RES_W-1:0] r_result;
    logic [OUT_W-1:0] r_res_data;
    logic [2:0]       r_idx;
    logic             r_valid;
    logic             r_last;
    logic             w_hs;
    logic [2:0]       w_idx_nxt;

    assign w_hs      = r_valid & i_res_ready;
    assign w_idx_nxt = r_idx + 3'd1;
    assign o_last_hs = w_hs & (r_idx == 3'(N_OUT - 1));

    // Result capture and word advance; abort outranks capture and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_res_data <= '0;
            r_idx      <= 3'd0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else if (i_abort) begin
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_capture) begin
            r_result   <= i_pe_out;
            r_res_data <= i_pe_out[OUT_W-1:0];
            r_idx      <= 3'd0;
            r_valid    <= 1'b1;
            r_last     <= 1'b0;
        end else if (w_hs) begin
            if (r_idx == 3'(N_OUT - 1)) begin
                r_idx   <= 3'd0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx      <= w_idx_nxt;
                r_res_data <= r_result[int'(w_idx_nxt) * OUT_W +: OUT_W];
                r_last     <= (w_idx_nxt == 3'(N_OUT - 1));
            end
        end
    end

    assign o_res_data  = r_res_data;
    assign o_res_idx   = r_idx;
    assign o_res_valid = r_valid;
    assign o_res_last  = r_last;

endmodule

// File: rtl/conv10x10_seq.sv
// Frame sequencer: loads filter and rows into the PE array, waits PE_LAT, drains results.
module conv10x10_seq
    import conv10x10_pkg::*;
#(
    parameter int unsigned PE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    conv10x10_seq_if.slave    io_bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_row_cnt;
    logic [3:0]        w_row_cnt_nxt;
    logic [3:0]        r_lat_cnt;
    logic [3:0]        w_lat_cnt_nxt;
    logic [PE_W-1:0]   r_pe_in;
    logic [FILT_W-1:0] r_pe_filter;
    logic              r_row_ready;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_row_hs;
    logic              w_row_wr;
    logic [3:0]        w_row_sel;
    logic              w_filt_wr;
    logic              w_capture;
    logic              w_last_hs;
    logic              w_frame_end;

    // row_ready is only ever high in IDLE/LOAD, so it alone qualifies the handshake.
    assign w_row_hs = io_bus.row_valid & r_row_ready;

    // Next-state, counter and write-enable decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        w_lat_cnt_nxt = r_lat_cnt;
        w_capture     = 1'b0;
        w_row_wr      = 1'b0;
        w_row_sel     = 4'd0;
        w_filt_wr     = 1'b0;
        w_frame_end   = 1'b0;
        if (io_bus.abort) begin
            w_state_nxt   = ST_IDLE;
            w_row_cnt_nxt = 4'd0;
            w_lat_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_filt_wr = io_bus.filt_load;
                    if (w_row_hs) begin
                        w_row_wr      = 1'b1;
                        w_row_sel     = 4'd0;
                        w_row_cnt_nxt = 4'd1;
                        w_state_nxt   = ST_LOAD;
                    end else begin
                        w_row_wr = 1'b0;
                    end
                end
                ST_LOAD: begin
                    w_filt_wr = io_bus.filt_load & (r_row_cnt == 4'd0);
                    if (w_row_hs) begin
                        w_row_wr      = 1'b1;
                        w_row_sel     = r_row_cnt;
                        w_row_cnt_nxt = r_row_cnt + 4'd1;
                        if (r_row_cnt == 4'(ROWS - 1)) begin
                            w_state_nxt   = ST_WAIT;
                            w_lat_cnt_nxt = 4'd0;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_row_wr = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_lat_cnt == 4'(PE_LAT - 1)) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_lat_cnt_nxt = r_lat_cnt + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_hs) begin
                        w_state_nxt   = ST_IDLE;
                        w_row_cnt_nxt = 4'd0;
                        w_frame_end   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters, array input buses and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row_cnt    <= 4'd0;
            r_lat_cnt    <= 4'd0;
            r_pe_in      <= '0;
            r_pe_filter  <= '0;
            r_row_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row_cnt    <= w_row_cnt_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_row_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_frame_end;
            if (w_row_wr) begin
                r_pe_in[row_lsb(w_row_sel) +: ROW_W] <= io_bus.row_data;
            end
            if (w_filt_wr) begin
                r_pe_filter <= io_bus.filt_data;
            end
        end
    end

    conv10x10_res_drain u_drain (
        .clk         (clk),
        .rst         (rst),
        .i_abort     (io_bus.abort),
        .i_capture   (w_capture),
        .i_pe_out    (io_bus.pe_out),
        .i_res_ready (io_bus.res_ready),
        .o_res_data  (io_bus.res_data),
        .o_res_idx   (io_bus.res_idx),
        .o_res_valid (io_bus.res_valid),
        .o_res_last  (io_bus.res_last),
        .o_last_hs   (w_last_hs)
    );

    assign io_bus.row_ready  = r_row_ready;
    assign io_bus.pe_in      = r_pe_in;
    assign io_bus.pe_filter  = r_pe_filter;
    assign io_bus.busy       = r_busy;
    assign io_bus.frame_done = r_frame_done;

endmodule

// File: doc/conv10x10_seq.md
Name: conv10x10_seq

Overview:
- Sequencer for the 10x10 convolution PE array (24 PEs, 3x3 filter, eight 16-bit row sums).
- Loads the 18-bit filter and assembles a 10-row image frame from a 20-bit row stream. Holds the array inputs stable for PE_LAT cycles, then captures the 128-bit result.
- Drains the result as eight 16-bit words over a valid/ready handshake.
- Sits between the image/weight source and the array top; the array itself is unchanged and stays reset-less.

Parameters:
- ROWS, 10, image rows per frame.
- ROW_W, 20, bits per image row (10 pixels x 2 b).
- FILT_W, 18, filter bits (3 rows x 6 b).
- OUT_W, 16, bits per result word.
- N_OUT, 8, result words per frame (ROWS-2).
- PE_LAT, 4, cycles pe_in must be held before pe_out is valid (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- filt_data  in  18  filter word; bits [5:0] = filter row 0.
- filt_load  in  1  load strobe for filt_data.
- row_data  in  20  image row.
- row_valid  in  1  row_data valid.
- row_ready  out  1  controller accepts a row.
- abort  in  1  synchronous frame cancel.
- pe_in  out  200  array image bus; row i at [20*i+19:20*i].
- pe_filter  out  18  array filter bus.
- pe_out  in  128  array result; word k at [16*k+15:16*k].
- res_data  out  16  result word.
- res_idx  out  3  index of res_data (0..7).
- res_valid  out  1  res_data valid.
- res_ready  in  1  downstream accepts the word.
- res_last  out  1  high with res_idx==7.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset: every register and output is 0 (pe_in, pe_filter, res_*, row_ready, busy, frame_done); state=IDLE. Reset asserted mid-frame discards everything.
- States: IDLE, LOAD, WAIT, DRAIN.
- IDLE: row_ready=1. A row handshake (row_valid & row_ready) writes row 0, sets row_cnt=1 and moves to LOAD.
- LOAD: row_ready=1. Each handshake writes pe_in slice row_cnt and increments row_cnt. On the handshake with row_cnt==ROWS-1, go to WAIT with lat_cnt=0; row_ready is 0 from the next cycle.
- Rows are written in-place the cycle after the handshake; untouched slices keep the previous frame's data.
- filt_load: updates pe_filter only in IDLE, or in LOAD with row_cnt==0. Ignored in every other state; there is no error flag.
- Simultaneous filt_load and the first row handshake are both accepted.
- WAIT: pe_in and pe_filter are frozen. lat_cnt increments each cycle. When lat_cnt==PE_LAT-1, pe_out is captured into a 128-bit result register and the state goes to DRAIN with out_idx=0.
- Frame latency: last row handshake to first res_valid = PE_LAT+1 cycles.
- DRAIN:
  - res_valid=1; res_data=result[16*out_idx +: 16]; res_idx=out_idx; res_last=(out_idx==N_OUT-1).
  - res_data and res_idx are stable while res_valid & !res_ready.
  - On handshake, out_idx increments. The handshake on the last word returns to IDLE, pulses frame_done for 1 cycle and clears row_cnt.
  - Back-to-back: 8 words in 8 cycles with res_ready held high.
  - A row presented during DRAIN is not accepted (row_ready=0).
- abort: in any state, forces IDLE next cycle, with row_cnt, lat_cnt and out_idx cleared and res_valid=0. pe_in and pe_filter are retained. No frame_done is pulsed. abort has priority over all handshakes in the same cycle.
- Arithmetic: no arithmetic on data; counters are 4 b for row_cnt and lat_cnt, 3 b for out_idx. Counters never wrap, because state exits occur before overflow.

Decomposition:
- Package conv10x10_pkg holds:
  - state enum (IDLE/LOAD/WAIT/DRAIN);
  - localparams ROWS, ROW_W, FILT_W, OUT_W, N_OUT;
  - function row_lsb(i)=i*ROW_W.
- One natural sub-module, conv10x10_res_drain: the 128-bit capture register plus the 16-bit word serialiser with valid/ready. The FSM stays in the top.

Test Plan:
- Reset mid-LOAD after 5 rows -> all outputs 0 immediately; the next frame starts at row 0.
- filt_data=18'h15555 with filt_load, then rows 20'h00001..20'h0000A with row_valid held, PE_LAT=4.
  - Expected: pe_filter=18'h15555; pe_in slice i = i+1.
  - Expected: row_ready drops after the 10th handshake; res_valid rises 5 cycles after that handshake.
- Bench stub drives pe_out = {16'd7,16'd6,...,16'd0}; res_ready=1 -> res_data 0..7 on consecutive cycles, res_idx matches, res_last only on word 7, frame_done one cycle later.
- res_ready toggling 1,0,0,1,... -> each word held stable while stalled, no word skipped or repeated, 8 handshakes total.
- filt_load=1 with 18'h3FFFF during WAIT -> pe_filter unchanged. Also, a row_valid held during DRAIN -> not accepted.
- abort asserted in the same cycle as the 3rd result handshake -> IDLE next cycle, no frame_done, res_valid=0, and a new 10-row frame then completes normally.
